// File: rtl/door_request_ctrl.sv
// Door toggle request controller: debounces the door button, applies the cooking interlock, drives a held
// door_toggle pulse and checks the servo's door_open feedback. Define AUTO_CLOSE_EN for the idle auto-close timer.
module door_request_ctrl #(
  parameter int unsigned DEBOUNCE_CYC   = 1_000_000,
  parameter int unsigned HOLD_CYC       = 100_000,
  parameter int unsigned ACK_TMO        = 200_000,
  parameter int unsigned AUTO_CLOSE_CYC = 32'd3_000_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_door,
  input  logic cooking,
  input  logic door_open,
  output logic door_toggle,
  output logic busy,
  output logic reject,
  output logic fault
);

  localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned SEQ_MAX = (HOLD_CYC > ACK_TMO) ? HOLD_CYC : ACK_TMO;
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [SEQ_W-1:0] HOLD_LAST = SEQ_W'(HOLD_CYC - 1);
  localparam logic [SEQ_W-1:0] ACK_LAST  = SEQ_W'(ACK_TMO - 1);

  typedef enum logic [1:0] {IDLE, HOLD_HI, WAIT_ACK, HOLD_LO} state_t;

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press_q, press_d;

  state_t           state_q;
  logic [SEQ_W-1:0] seq_cnt_q;
  logic             start_state_q;
  logic             toggle_q, busy_q, reject_q, fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_cnt_q <= '0;
      press_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep the two synchronizer stages as separate flops.
      sync1_q  <= btn_door;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
      press_q  <= press_d;
    end
  end

  // The debounced level only moves after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    db_d     = db_q;
    db_cnt_d = '0;
    press_d  = 1'b0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d    = sync2_q;
        press_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

`ifdef AUTO_CLOSE_EN
  logic [31:0] idle_cnt_q;
`else
  logic unused_auto_close;
  assign unused_auto_close = ^AUTO_CLOSE_CYC;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      seq_cnt_q     <= '0;
      start_state_q <= 1'b0;
      toggle_q      <= 1'b0;
      busy_q        <= 1'b0;
      reject_q      <= 1'b0;
      fault_q       <= 1'b0;
`ifdef AUTO_CLOSE_EN
      idle_cnt_q    <= '0;
`endif
    end else begin
      reject_q <= 1'b0;
`ifdef AUTO_CLOSE_EN
      idle_cnt_q <= '0;
`endif
      case (state_q)
        IDLE: begin
`ifdef AUTO_CLOSE_EN
          if (!press_q && door_open && (idle_cnt_q != AUTO_CLOSE_CYC))
            idle_cnt_q <= idle_cnt_q + 32'd1;
`endif
          if (press_q) begin
            if (!door_open && cooking) begin
              reject_q <= 1'b1;
            end else begin
              start_state_q <= door_open;
              state_q       <= HOLD_HI;
              toggle_q      <= 1'b1;
              busy_q        <= 1'b1;
              seq_cnt_q     <= '0;
            end
          end
`ifdef AUTO_CLOSE_EN
          else if (door_open && (idle_cnt_q == AUTO_CLOSE_CYC)) begin
            start_state_q <= 1'b1;
            state_q       <= HOLD_HI;
            toggle_q      <= 1'b1;
            busy_q        <= 1'b1;
            seq_cnt_q     <= '0;
          end
`endif
        end
        HOLD_HI: begin
          if (seq_cnt_q == HOLD_LAST) begin
            state_q   <= WAIT_ACK;
            toggle_q  <= 1'b0;
            seq_cnt_q <= '0;
          end else begin
            seq_cnt_q <= seq_cnt_q + SEQ_W'(1);
          end
        end
        WAIT_ACK: begin
          // A feedback change wins over a simultaneous timeout.
          if (door_open != start_state_q) begin
            state_q   <= HOLD_LO;
            seq_cnt_q <= '0;
          end else if (seq_cnt_q == ACK_LAST) begin
            fault_q   <= 1'b1;
            state_q   <= HOLD_LO;
            seq_cnt_q <= '0;
          end else begin
            seq_cnt_q <= seq_cnt_q + SEQ_W'(1);
          end
        end
        HOLD_LO: begin
          if (seq_cnt_q == HOLD_LAST) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            seq_cnt_q <= '0;
          end else begin
            seq_cnt_q <= seq_cnt_q + SEQ_W'(1);
          end
        end
        default: begin
          state_q  <= IDLE;
          toggle_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign door_toggle = toggle_q;
  assign busy        = busy_q;
  assign reject      = reject_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_door_request_ctrl.sv
// Self-checking bench for door_request_ctrl: directed sequence with randomized timings, checked against
// event times derived arithmetically from the press/servo timing rules.
module tb_door_request_ctrl;

  localparam int D  = 8;
  localparam int H  = 16;
  localparam int A  = 32;
  localparam int AC = 64;

  logic clk = 1'b0;
  logic reset, btn_door, cooking, door_open;
  logic door_toggle, busy, reject, fault;

  door_request_ctrl #(
    .DEBOUNCE_CYC  (D),
    .HOLD_CYC      (H),
    .ACK_TMO       (A),
    .AUTO_CLOSE_CYC(AC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_door   (btn_door),
    .cooking    (cooking),
    .door_open  (door_open),
    .door_toggle(door_toggle),
    .busy       (busy),
    .reject     (reject),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: cycle stamps of output edges, sampled shortly after each clock edge.
  int   n_rise = 0, rise_cyc = 0, fall_cyc = 0;
  int   n_busy_rise = 0, busy_rise_cyc = 0, busy_fall_cyc = 0;
  int   rej_cycles = 0, rej_cyc = 0, fault_cyc = 0;
  logic p_tog = 1'b0, p_busy = 1'b0, p_rej = 1'b0, p_fault = 1'b0;

  always begin
    @(posedge clk);
    #2;
    if (door_toggle === 1'b1 && p_tog !== 1'b1) begin n_rise++; rise_cyc = cyc; end
    if (door_toggle === 1'b0 && p_tog === 1'b1) fall_cyc = cyc;
    if (busy === 1'b1 && p_busy !== 1'b1) begin n_busy_rise++; busy_rise_cyc = cyc; end
    if (busy === 1'b0 && p_busy === 1'b1) busy_fall_cyc = cyc;
    if (reject === 1'b1) begin rej_cycles++; if (p_rej !== 1'b1) rej_cyc = cyc; end
    if (fault === 1'b1 && p_fault !== 1'b1) fault_cyc = cyc;
    p_tog = door_toggle; p_busy = busy; p_rej = reject; p_fault = fault;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  // Press for 'hold' cycles; flip door_open at press+flip_rel and raise cooking at press+cook_rel (-1 = never).
  task automatic drive(input int hold, input int flip_rel, input int cook_rel, input int span, output int t0);
    @(negedge clk);
    btn_door = 1'b1;
    t0 = cyc;
    while (cyc < t0 + span) begin
      @(negedge clk);
      if (cyc == t0 + hold) btn_door = 1'b0;
      if (flip_rel >= 0 && cyc == t0 + flip_rel) door_open = ~door_open;
      if (cook_rel >= 0 && cyc == t0 + cook_rel) cooking = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, r0, b0, j0, x0, dly, k, gl, gap;

    reset = 1'b1; btn_door = 1'b0; cooking = 1'b0; door_open = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_toggle", door_toggle, 0);
    check("reset_busy",   busy,        0);
    check("reset_reject", reject,      0);
    check("reset_fault",  fault,       0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Test 1: short glitches, then a real open press; fast servo; cooking rises mid HOLD_HI.
    r0 = n_rise; j0 = rej_cycles;
    for (int i = 0; i < 3; i++) begin
      gl  = $urandom_range(1, D - 1);
      gap = $urandom_range(2, 5);
      btn_door = 1'b1;
      repeat (gl) @(negedge clk);
      btn_door = 1'b0;
      repeat (gap) @(negedge clk);
    end
    repeat (D + 4) @(negedge clk);
    check("glitch_no_toggle", n_rise - r0, 0);
    dly = $urandom_range(1, H - 1);
    drive(20, D + 3 + dly, D + 5, D + 3 + 2 * H + 1 + 20, t0);
    check("open_one_pulse",  n_rise - r0, 1);
    check("open_rise_time",  rise_cyc, t0 + D + 3);
    check("open_pulse_len",  fall_cyc - rise_cyc, H);
    check("open_busy_rise",  busy_rise_cyc, t0 + D + 3);
    check("open_busy_len",   busy_fall_cyc - busy_rise_cyc, 2 * H + 1);
    check("open_fault",      fault, 0);
    check("open_no_reject",  rej_cycles - j0, 0);
    check("open_door_state", door_open, 1);

    // Test 2: close while cooking=1; servo answers k cycles into WAIT_ACK territory.
    r0 = n_rise; j0 = rej_cycles;
    k = $urandom_range(1, A - 2);
    drive(20, D + 3 + H + k, -1, D + 3 + 2 * H + k + 11, t0);
    check("close_one_pulse", n_rise - r0, 1);
    check("close_rise_time", rise_cyc, t0 + D + 3);
    check("close_busy_fall", busy_fall_cyc, t0 + D + 3 + 2 * H + k + 1);
    check("close_no_reject", rej_cycles - j0, 0);
    check("close_fault",     fault, 0);

    // Test 3: open request while cooking -> single reject pulse, nothing else.
    r0 = n_rise; b0 = n_busy_rise; j0 = rej_cycles;
    drive(20, -1, -1, 40, t0);
    check("reject_cycles",   rej_cycles - j0, 1);
    check("reject_time",     rej_cyc, t0 + D + 3);
    check("reject_no_pulse", n_rise - r0, 0);
    check("reject_no_busy",  n_busy_rise - b0, 0);

    // Test 4: no feedback -> fault after ACK_TMO, HOLD_LO still runs; fault survives next sequence.
    cooking = 1'b0;
    drive(20, -1, -1, D + 3 + 2 * H + A + 10, t0);
    check("tmo_fault",       fault, 1);
    check("tmo_fault_time",  fault_cyc, t0 + D + 3 + H + A);
    check("tmo_busy_fall",   busy_fall_cyc, t0 + D + 3 + 2 * H + A);
    drive(20, D + 3 + 4, -1, 64, t1);
    check("tmo_next_rise",   rise_cyc, t1 + D + 3);
    check("tmo_next_busy",   busy_fall_cyc, t1 + D + 3 + 2 * H + 1);
    check("fault_sticky",    fault, 1);

    // Test 5: second press during busy is discarded.
    r0 = n_rise;
    @(negedge clk);
    btn_door = 1'b1;
    t0 = cyc;
    while (cyc < t0 + 90) begin
      @(negedge clk);
      if (cyc == t0 + 12) btn_door = 1'b0;
      if (cyc == t0 + 24) btn_door = 1'b1;
      if (cyc == t0 + 36) btn_door = 1'b0;
      if (cyc == t0 + D + 3 + 3) door_open = ~door_open;
    end
    check("busy_one_pulse",  n_rise - r0, 1);
    check("busy_pulse_len",  fall_cyc - rise_cyc, H);
    check("busy_fall_time",  busy_fall_cyc, t0 + D + 3 + 2 * H + 1);
    check("fault_still_set", fault, 1);

    // Reset in the middle of HOLD_HI.
    @(negedge clk);
    btn_door = 1'b1;
    t0 = cyc;
    wait_until(t0 + D + 3 + 5);
    check("pre_reset_toggle", door_toggle, 1);
    reset = 1'b1;
    btn_door = 1'b0;
    @(negedge clk);
    check("rst_mid_toggle", door_toggle, 0);
    check("rst_mid_busy",   busy, 0);
    check("rst_mid_fault",  fault, 0);
    @(negedge clk);

    // Test 6: door left open and idle.
    reset = 1'b0;
    door_open = 1'b1;
    cooking = 1'b0;
    x0 = cyc;
    r0 = n_rise;
`ifdef AUTO_CLOSE_EN
    wait_until(x0 + AC + 10);
    check("auto_close_pulse", n_rise - r0, 1);
    check("auto_close_time",  rise_cyc, x0 + AC + 1);
`else
    wait_until(x0 + 1000);
    check("no_auto_close", n_rise - r0, 0);
    check("idle_not_busy", busy, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
